// File: rtl/moving_sum_len_ctrl.sv
// Runtime window-length controller for a moving_sum stage: applies length updates
// at packet boundaries after draining the pipe, and optionally drops warm-up sums.
module moving_sum_len_ctrl #(
  parameter int MAX_LEN      = 1023,
  parameter int DEFAULT_LEN  = 16,
  parameter int WIDTH        = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int DROP_WARMUP  = 1,
  localparam int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_len_stb,
  input  logic [LW-1:0]    cfg_len,
  output logic             cfg_busy,
  output logic [LW-1:0]    len,
  output logic             clear,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tlast,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] ms_i_tdata,
  output logic             ms_i_tlast,
  output logic             ms_i_tvalid,
  input  logic             ms_i_tready,
  input  logic [WIDTH-1:0] ms_o_tdata,
  input  logic             ms_o_tlast,
  input  logic             ms_o_tvalid,
  output logic             ms_o_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {RUN, WAIT_EOP, DRAIN, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [LW-1:0] warm_q, warm_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          in_pkt_q, in_pkt_d;

  logic          gate_open, s_hs, mso_hs, drop;
  logic [LW-1:0] cap_len;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] v);
    if (v == '0) return LW'(1);
    if (32'(v) > 32'(MAX_LEN)) return LW'(MAX_LEN);
    return v;
  endfunction

  assign gate_open   = ((state_q == RUN) || (state_q == WAIT_EOP)) &&
                       (inflight_q < IW'(MAX_INFLIGHT));
  assign ms_i_tvalid = s_tvalid & gate_open;
  assign s_tready    = ms_i_tready & gate_open;
  assign ms_i_tdata  = s_tdata;
  assign ms_i_tlast  = s_tlast;
  assign s_hs        = s_tvalid & s_tready;

  // Partial-window sums are swallowed, but a packet's tlast always gets through.
  assign drop        = (warm_q != '0) && !ms_o_tlast;
  assign ms_o_tready = drop ? 1'b1 : o_tready;
  assign o_tvalid    = drop ? 1'b0 : ms_o_tvalid;
  assign o_tdata     = ms_o_tdata;
  assign o_tlast     = ms_o_tlast;
  assign mso_hs      = ms_o_tvalid & ms_o_tready;

  assign len      = len_q;
  assign clear    = (state_q == CLEAR);
  assign cfg_busy = pend_vld_q || (state_q != RUN);
  assign cap_len  = clamp_len(cfg_len);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    warm_d     = warm_q;
    inflight_d = inflight_q;
    in_pkt_d   = in_pkt_q;

    if (s_hs) in_pkt_d = !s_tlast;

    case ({s_hs, mso_hs})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (mso_hs && (warm_q != '0)) warm_d = warm_q - LW'(1);

    // A no-op request is only filtered when nothing is already queued.
    if (cfg_len_stb &&
        !((state_q == RUN) && !pend_vld_q && (cap_len == len_q))) begin
      pend_vld_d = 1'b1;
      pend_d     = cap_len;
    end

    case (state_q)
      RUN:      if (pend_vld_q) state_d = in_pkt_d ? WAIT_EOP : DRAIN;
      WAIT_EOP: if (s_hs && s_tlast) state_d = DRAIN;
      DRAIN:    if (inflight_q == '0) state_d = CLEAR;
      CLEAR: begin
        state_d = RUN;
        len_d   = pend_q;
        warm_d  = (DROP_WARMUP != 0) ? pend_q - LW'(1) : '0;
        if (!cfg_len_stb) pend_vld_d = 1'b0;
      end
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      len_q      <= LW'(DEFAULT_LEN);
      pend_vld_q <= 1'b0;
      warm_q     <= (DROP_WARMUP != 0) ? LW'(DEFAULT_LEN - 1) : '0;
      inflight_q <= '0;
      in_pkt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pend_vld_q <= pend_vld_d;
      warm_q     <= warm_d;
      inflight_q <= inflight_d;
      in_pkt_q   <= in_pkt_d;
    end
  end

  // The pending length is qualified by pend_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule
